// File: rtl/code_verifier.sv
// code_verifier: checks a 5-digit decimal code entered by the user against the
// current and previous hasher keys, pulsing accept/reject and locking out
// further entries after repeated failures until enough key ticks have passed.
module code_verifier #(
    parameter int MAX_FAILS  = 3,
    parameter int LOCK_TICKS = 4
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        key_tick,
    input  logic [15:0] hash_in,
    input  logic        digit_valid,
    input  logic [3:0]  digit_in,
    input  logic        clear,
    output logic        accept,
    output logic        reject,
    output logic        busy,
    output logic        locked,
    output logic [2:0]  digit_count
);

    localparam logic [2:0] MAX_FAILS_C  = 3'(MAX_FAILS);
    localparam logic [3:0] LOCK_TICKS_C = 4'(LOCK_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        CHECK,
        LOCKED
    } state_t;

    state_t      state, state_nxt;
    logic [16:0] acc, acc_nxt;
    logic        bad, bad_nxt;
    logic [2:0]  digit_cnt, digit_cnt_nxt;
    logic [2:0]  fail_cnt, fail_cnt_nxt;
    logic [3:0]  lock_cnt, lock_cnt_nxt;
    logic        accept_nxt, reject_nxt;
    logic [15:0] prev_hash;
    logic        prev_valid;

    logic        digit_ok;
    logic [16:0] digit_val;
    logic [16:0] acc_shift;
    logic        code_match;

    // An illegal BCD digit contributes nothing to the value; the sticky bad
    // flag is what makes the code fail.
    assign digit_ok   = (digit_in <= 4'd9);
    assign digit_val  = digit_ok ? {13'd0, digit_in} : 17'd0;
    assign acc_shift  = (acc * 17'd10) + digit_val;
    assign code_match = !bad && !acc[16] &&
                        ((acc[15:0] == hash_in) ||
                         (prev_valid && (acc[15:0] == prev_hash)));

    assign busy        = (state == ENTRY) || (state == CHECK);
    assign locked      = (state == LOCKED);
    assign digit_count = digit_cnt;

    // Remember the key of the previous time step so a slightly late entry still passes.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            prev_hash  <= 16'd0;
            prev_valid <= 1'b0;
        end else if (key_tick) begin
            prev_hash  <= hash_in;
            prev_valid <= 1'b1;
        end
    end

    // State register plus the entry, fail and lockout bookkeeping.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 17'd0;
            bad       <= 1'b0;
            digit_cnt <= 3'd0;
            fail_cnt  <= 3'd0;
            lock_cnt  <= 4'd0;
            accept    <= 1'b0;
            reject    <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            bad       <= bad_nxt;
            digit_cnt <= digit_cnt_nxt;
            fail_cnt  <= fail_cnt_nxt;
            lock_cnt  <= lock_cnt_nxt;
            accept    <= accept_nxt;
            reject    <= reject_nxt;
        end
    end

    // Next-state logic: collect digits, judge the code for one cycle, and count down lockouts.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        bad_nxt       = bad;
        digit_cnt_nxt = digit_cnt;
        fail_cnt_nxt  = fail_cnt;
        lock_cnt_nxt  = lock_cnt;
        accept_nxt    = 1'b0;
        reject_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (clear) begin
                    acc_nxt       = 17'd0;
                    bad_nxt       = 1'b0;
                    digit_cnt_nxt = 3'd0;
                end else if (digit_valid) begin
                    acc_nxt       = digit_val;
                    bad_nxt       = !digit_ok;
                    digit_cnt_nxt = 3'd1;
                    state_nxt     = ENTRY;
                end
            end
            ENTRY: begin
                if (clear) begin
                    acc_nxt       = 17'd0;
                    bad_nxt       = 1'b0;
                    digit_cnt_nxt = 3'd0;
                    state_nxt     = IDLE;
                end else if (digit_valid) begin
                    acc_nxt       = acc_shift;
                    bad_nxt       = bad | !digit_ok;
                    digit_cnt_nxt = digit_cnt + 3'd1;
                    if (digit_cnt == 3'd4) begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                acc_nxt       = 17'd0;
                bad_nxt       = 1'b0;
                digit_cnt_nxt = 3'd0;
                if (code_match) begin
                    accept_nxt   = 1'b1;
                    fail_cnt_nxt = 3'd0;
                    state_nxt    = IDLE;
                end else begin
                    reject_nxt = 1'b1;
                    if ((fail_cnt + 3'd1) == MAX_FAILS_C) begin
                        fail_cnt_nxt = 3'd0;
                        lock_cnt_nxt = LOCK_TICKS_C;
                        state_nxt    = LOCKED;
                    end else begin
                        fail_cnt_nxt = fail_cnt + 3'd1;
                        state_nxt    = IDLE;
                    end
                end
            end
            LOCKED: begin
                if (key_tick) begin
                    lock_cnt_nxt = lock_cnt - 4'd1;
                    if (lock_cnt == 4'd1) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_code_verifier.sv
// tb_code_verifier: directed test-plan scenarios followed by random entries,
// all checked against a value-level model of the key check and lockout rules.
module tb_code_verifier;

    localparam int MAX_FAILS  = 3;
    localparam int LOCK_TICKS = 4;

    logic        sysclk;
    logic        rst_n;
    logic        key_tick;
    logic [15:0] hash_in;
    logic        digit_valid;
    logic [3:0]  digit_in;
    logic        clear;
    logic        accept;
    logic        reject;
    logic        busy;
    logic        locked;
    logic [2:0]  digit_count;

    int vectors;
    int miscompares;

    // Model: current/previous key, fail count, key ticks left in lockout.
    logic [15:0] m_cur;
    logic [15:0] m_prev;
    bit          m_pv;
    int          m_fails;
    int          m_lock_left;

    code_verifier #(
        .MAX_FAILS  (MAX_FAILS),
        .LOCK_TICKS (LOCK_TICKS)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .key_tick    (key_tick),
        .hash_in     (hash_in),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .clear       (clear),
        .accept      (accept),
        .reject      (reject),
        .busy        (busy),
        .locked      (locked),
        .digit_count (digit_count)
    );

    // Free-running system clock.
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit model_match(input logic [19:0] dg);
        int  v;
        bit  ok;
        int  d;
        v  = 0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = int'(dg[19-4*i -: 4]);
            if (d > 9) ok = 1'b0;
            else       v = v * 10 + d;
        end
        return ok && (v <= 65535) &&
               ((v == int'(m_cur)) || (m_pv && (v == int'(m_prev))));
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic keyStep(input logic [15:0] new_hash);
        key_tick = 1'b1;
        tick();
        key_tick = 1'b0;
        hash_in  = new_hash;
        m_prev   = m_cur;
        m_pv     = 1'b1;
        m_cur    = new_hash;
        if (m_lock_left > 0) m_lock_left--;
        checkOutput("key_locked", 32'(locked), 32'(m_lock_left > 0));
    endtask

    // Enter five digits and check the count, busy, result pulse and lock status.
    task automatic applyStimulus(input logic [19:0] dg, input string tag);
        bit was_locked;
        bit exp_acc;
        bit exp_rej;
        was_locked = (m_lock_left > 0);
        exp_acc = 1'b0;
        exp_rej = 1'b0;
        for (int i = 0; i < 5; i++) begin
            digit_valid = 1'b1;
            digit_in    = dg[19-4*i -: 4];
            tick();
            checkOutput({tag, "_cnt"}, 32'(digit_count), was_locked ? 32'd0 : 32'(i + 1));
        end
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        checkOutput({tag, "_busy_chk"}, 32'(busy), 32'(!was_locked));
        if (!was_locked) begin
            if (model_match(dg)) begin
                exp_acc = 1'b1;
                m_fails = 0;
            end else begin
                exp_rej = 1'b1;
                m_fails++;
                if (m_fails == MAX_FAILS) begin
                    m_fails     = 0;
                    m_lock_left = LOCK_TICKS;
                end
            end
        end
        tick();
        checkOutput({tag, "_accept"}, 32'(accept), 32'(exp_acc));
        checkOutput({tag, "_reject"}, 32'(reject), 32'(exp_rej));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_locked"}, 32'(locked), 32'(m_lock_left > 0));
        checkOutput({tag, "_cnt_end"}, 32'(digit_count), 32'd0);
        tick();
        checkOutput({tag, "_pulse_end"}, 32'({accept, reject}), 32'd0);
    endtask

    // Enter a partial code, then clear together with one more digit strobe.
    task automatic applyClear(input int ndig);
        for (int i = 0; i < ndig; i++) begin
            digit_valid = 1'b1;
            digit_in    = 4'($urandom_range(0, 9));
            tick();
        end
        digit_valid = 1'b1;
        clear       = 1'b1;
        digit_in    = 4'd5;
        tick();
        digit_valid = 1'b0;
        clear       = 1'b0;
        checkOutput("clr_cnt", 32'(digit_count), 32'd0);
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_locked", 32'(locked), 32'(m_lock_left > 0));
        tick();
        checkOutput("clr_pulse", 32'({accept, reject}), 32'd0);
    endtask

    // Drop rst_n in the middle of a partial entry and check everything cleared.
    task automatic applyResetMidEntry();
        for (int i = 0; i < 2; i++) begin
            digit_valid = 1'b1;
            digit_in    = 4'd1;
            tick();
        end
        digit_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_outputs", 32'({accept, reject, busy, locked, digit_count}), 32'd0);
        tick();
        rst_n = 1'b1;
        m_pv        = 1'b0;
        m_fails     = 0;
        m_lock_left = 0;
        tick();
        checkOutput("rst_cnt", 32'(digit_count), 32'd0);
    endtask

    initial begin
        int choice;
        logic [19:0] dg;
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        key_tick     = 1'b0;
        hash_in      = 16'd0;
        digit_valid  = 1'b0;
        digit_in     = 4'd0;
        clear        = 1'b0;
        m_cur        = 16'd0;
        m_prev       = 16'd0;
        m_pv         = 1'b0;
        m_fails      = 0;
        m_lock_left  = 0;

        repeat (2) @(posedge sysclk);
        #1;
        checkOutput("reset_accept", 32'(accept), 32'd0);
        checkOutput("reset_reject", 32'(reject), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_cnt", 32'(digit_count), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] current-key and previous-key matching");
        keyStep(16'h1234);
        keyStep(16'hBEEF);
        applyStimulus(20'h48879, "cur_match");
        applyStimulus(20'h04660, "prev_match");
        keyStep(16'h0001);
        applyStimulus(20'h04660, "stale_key");

        $display("[TB] invalid codes");
        applyStimulus(20'h65536, "overflow");
        applyStimulus(20'h00001, "cur_small");
        keyStep(16'h1234);
        applyStimulus(20'h04A60, "bad_digit");
        applyStimulus(20'h00001, "prev_small");

        $display("[TB] lockout");
        applyStimulus(20'h11111, "wrong1");
        applyStimulus(20'h11111, "wrong2");
        applyStimulus(20'h11111, "wrong3");
        applyStimulus(20'h04660, "while_locked");
        applyClear(2);
        keyStep(16'h1111);
        keyStep(16'h2222);
        keyStep(16'h3333);
        keyStep(16'h4444);
        applyStimulus(20'h17476, "after_lock");

        $display("[TB] fail counter reset by accept");
        applyStimulus(20'h11111, "fc_wrong1");
        applyStimulus(20'h11111, "fc_wrong2");
        applyStimulus(20'h17476, "fc_good");
        applyStimulus(20'h11111, "fc_wrong3");
        applyStimulus(20'h11111, "fc_wrong4");
        applyStimulus(20'h17476, "fc_good2");

        $display("[TB] clear and reset mid-entry");
        applyClear(3);
        applyStimulus(20'h17476, "after_clear");
        applyResetMidEntry();
        applyStimulus(20'h13107, "prev_after_rst");
        applyStimulus(20'h17476, "cur_after_rst");

        $display("[TB] random entries");
        for (int n = 0; n < 60; n++) begin
            choice = $urandom_range(0, 7);
            case (choice)
                0, 1: keyStep(16'($urandom));
                2: applyStimulus(to_bcd(int'(m_cur)), "rnd_cur");
                3: applyStimulus(to_bcd(m_pv ? int'(m_prev) : int'(m_cur)), "rnd_prev");
                4: applyStimulus(to_bcd($urandom_range(0, 99999)), "rnd_val");
                5: begin
                    for (int i = 0; i < 5; i++) dg[4*i +: 4] = 4'($urandom_range(0, 15));
                    applyStimulus(dg, "rnd_digits");
                end
                6: applyClear($urandom_range(1, 4));
                default: repeat ($urandom_range(1, 3)) tick();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
